// File: rtl/serial_parity_checker_if.sv
// Serial receive link bundle: bit stream in from the channel, checked words out to the consumer.
interface serial_parity_checker_if #(
  parameter int DATA_W = 3
);
  logic              in;
  logic              bit_valid;
  logic              sof;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_err;
  logic              frame_abort;
  logic [7:0]        err_cnt;

  modport master (
    output in, bit_valid, sof,
    input  data_out, frame_done, parity_err, frame_abort, err_cnt
  );

  modport slave (
    input  in, bit_valid, sof,
    output data_out, frame_done, parity_err, frame_abort, err_cnt
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Reassembles DATA_W-bit serial frames plus a parity bit and flags parity errors.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
  parameter int DATA_W = 3,
  parameter int ODD    = 0
) (
  input logic                  clk,
  input logic                  reset_n,
  serial_parity_checker_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam bit OddBit = (ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic              rp;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              perr_q;
  logic              abort_q;

  // The parity bit is accepted only from PARITY with a plain valid bit.
  logic parity_take;
  logic parity_bad;
  assign parity_take = bus.bit_valid && !bus.sof && (state == PARITY);
  assign parity_bad  = rp ^ bus.in ^ OddBit;

  // A sof always restarts the frame, so it is handled ahead of the state case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      rp      <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (bus.bit_valid) begin
        if (bus.sof) begin
          abort_q <= (state != IDLE);
          sh      <= DATA_W'(bus.in);
          rp      <= bus.in;
          cnt     <= CW'(1);
          state   <= (DATA_W == 1) ? PARITY : DATA;
        end else begin
          unique case (state)
            IDLE: begin
            end
            DATA: begin
              sh  <= (sh << 1) | DATA_W'(bus.in);
              rp  <= rp ^ bus.in;
              cnt <= cnt + CW'(1);
              if (cnt == CW'(DATA_W - 1)) state <= PARITY;
            end
            PARITY: begin
              data_q <= sh;
              perr_q <= parity_bad;
              done_q <= 1'b1;
              state  <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_q;

  // Saturates at 255; only reset brings it back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'd0;
    end else if (parity_take && parity_bad && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_q;
`else
  logic unused_cnt;
  assign unused_cnt  = parity_take;
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.data_out    = data_q;
  assign bus.frame_done  = done_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_abort = abort_q;
endmodule
